// File: rtl/instr_sequencer_if.sv
// Control/status bundle between instr_sequencer (master) and the 32-bit bus datapath (slave).
// The sequencer reads run/IR/mem_rdy and drives every datapath strobe plus status.
interface instr_sequencer_if;
  logic        run;
  logic [31:0] IR;
  logic        mem_rdy;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        PCin;
  logic        PCout;
  logic        MARin;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        Zlowin;
  logic        Zhighin;
  logic        Zlowout;
  logic        Zhighout;
  logic        HIin;
  logic        LOin;
  logic        IncPC;
  logic        Read;
  logic        ALU_MUL;
  logic        ALU_DIV;
  logic [3:0]  ALUop;
  logic        busy;
  logic        halted;
  logic        fault;

  modport master (
    input  run, IR, mem_rdy,
    output Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read,
           ALU_MUL, ALU_DIV, ALUop, busy, halted, fault
  );

  modport slave (
    output run, IR, mem_rdy,
    input  Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read,
           ALU_MUL, ALU_DIV, ALUop, busy, halted, fault
  );
endinterface

// File: rtl/instr_sequencer.sv
// Hardwired fetch/execute sequencer for the 32-bit bus datapath.
// Optional: define ILLEGAL_OP_TRAP_EN to trap illegal opcodes into HALT with fault set.
//
// state | meaning
// IDLE  | waiting for run
// T0    | PC -> MAR, Z <= PC+1
// T1    | Z -> PC, memory read into MDR, waits on mem_rdy
// T2    | MDR -> IR
// T3    | Rb -> Y (two-source ops), nop/halt/illegal resolved here
// T4    | ALU operation into Z (Zhigh too for mul/div)
// T5    | Zlow -> Ra, or Zlow -> LO for mul/div
// T6    | Zhigh -> HI (mul/div only)
// HALT  | stopped, leaves only through clear
module instr_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic               clock,
  input logic               clear,
  instr_sequencer_if.master bus
);

  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_BIN,
    C_UNARY,
    C_MUL,
    C_DIV,
    C_NOP,
    C_HALT,
    C_ILL
  } op_class_t;

  state_t          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            fault_q;

  logic [4:0]      opcode;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic [3:0]      rc;
  logic [15:0]     ra_oh;
  logic [15:0]     rb_oh;
  logic [15:0]     rc_oh;
  op_class_t       op_class;
  logic [3:0]      alu_sel;
  logic            is_muldiv;
  state_t          end_state;
  logic            unused_ir;

  assign opcode    = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];
  assign ra_oh     = 16'b1 << ra;
  assign rb_oh     = 16'b1 << rb;
  assign rc_oh     = 16'b1 << rc;
  assign is_muldiv = (op_class == C_MUL) || (op_class == C_DIV);
  assign end_state = bus.run ? S_T0 : S_IDLE;

  always_comb begin
    op_class = C_ILL;
    alu_sel  = 4'd0;
    case (opcode)
      5'b00011: begin op_class = C_BIN;   alu_sel = 4'd0;  end
      5'b00100: begin op_class = C_BIN;   alu_sel = 4'd1;  end
      5'b00101: begin op_class = C_BIN;   alu_sel = 4'd2;  end
      5'b00110: begin op_class = C_BIN;   alu_sel = 4'd3;  end
      5'b00111: begin op_class = C_BIN;   alu_sel = 4'd4;  end
      5'b01000: begin op_class = C_BIN;   alu_sel = 4'd5;  end
      5'b01001: begin op_class = C_BIN;   alu_sel = 4'd6;  end
      5'b01010: begin op_class = C_BIN;   alu_sel = 4'd7;  end
      5'b01011: begin op_class = C_BIN;   alu_sel = 4'd8;  end
      5'b10001: begin op_class = C_UNARY; alu_sel = 4'd9;  end
      5'b10010: begin op_class = C_UNARY; alu_sel = 4'd10; end
      5'b10000: begin op_class = C_MUL;   alu_sel = 4'd11; end
      5'b01111: begin op_class = C_DIV;   alu_sel = 4'd12; end
      5'b11010: op_class = C_NOP;
      5'b11011: op_class = C_HALT;
      default:  op_class = C_ILL;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.run) state_q <= S_T0;
        S_T0:   state_q <= S_T1;
        S_T1: begin
          // PCin stays high while waiting; Z is not reloaded, so PC is unchanged.
          if (bus.mem_rdy) begin
            state_q    <= S_T2;
            wait_cnt_q <= '0;
          end else if ((MEM_WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST)) begin
            state_q    <= S_HALT;
            wait_cnt_q <= '0;
            fault_q    <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_T2:   state_q <= S_T3;
        S_T3: begin
          case (op_class)
            C_NOP:  state_q <= end_state;
            C_HALT: state_q <= S_HALT;
            C_ILL: begin
`ifdef ILLEGAL_OP_TRAP_EN
              state_q <= S_HALT;
              fault_q <= 1'b1;
`else
              state_q <= end_state;
`endif
            end
            default: state_q <= S_T4;
          endcase
        end
        S_T4:   state_q <= S_T5;
        S_T5:   state_q <= is_muldiv ? S_T6 : end_state;
        S_T6:   state_q <= end_state;
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode: IR is loaded at the T2->T3 edge, so T3..T6 strobes must
  // follow the live IR rather than a pre-registered copy.
  logic [15:0] rin, rout;
  logic [3:0]  aluop;
  logic pc_in, pc_out, mar_in, mdr_in, mdr_out, ir_in, y_in;
  logic zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
  logic inc_pc, rd, alu_mul, alu_div;

  always_comb begin
    rin       = '0;
    rout      = '0;
    aluop     = 4'd0;
    pc_in     = 1'b0;
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    zlow_in   = 1'b0;
    zhigh_in  = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    inc_pc    = 1'b0;
    rd        = 1'b0;
    alu_mul   = 1'b0;
    alu_div   = 1'b0;
    case (state_q)
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        zlow_in = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        rd       = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if ((op_class == C_BIN) || is_muldiv) begin
          rout = rb_oh;
          y_in = 1'b1;
        end
      end
      S_T4: begin
        rout     = (op_class == C_UNARY) ? rb_oh : rc_oh;
        aluop    = alu_sel;
        zlow_in  = 1'b1;
        zhigh_in = is_muldiv;
        alu_mul  = (op_class == C_MUL);
        alu_div  = (op_class == C_DIV);
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_muldiv) lo_in = 1'b1;
        else           rin   = ra_oh;
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Rin      = rin;
  assign bus.Rout     = rout;
  assign bus.ALUop    = aluop;
  assign bus.PCin     = pc_in;
  assign bus.PCout    = pc_out;
  assign bus.MARin    = mar_in;
  assign bus.MDRin    = mdr_in;
  assign bus.MDRout   = mdr_out;
  assign bus.IRin     = ir_in;
  assign bus.Yin      = y_in;
  assign bus.Zlowin   = zlow_in;
  assign bus.Zhighin  = zhigh_in;
  assign bus.Zlowout  = zlow_out;
  assign bus.Zhighout = zhigh_out;
  assign bus.HIin     = hi_in;
  assign bus.LOin     = lo_in;
  assign bus.IncPC    = inc_pc;
  assign bus.Read     = rd;
  assign bus.ALU_MUL  = alu_mul;
  assign bus.ALU_DIV  = alu_div;
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted   = (state_q == S_HALT);
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle strobe vectors against hand-built expectations.
// A second instance with MEM_WAIT_MAX=2 covers the memory-timeout fault.
module tb_instr_sequencer;

  logic clock = 1'b0;
  logic clear;
  int   checks = 0;
  int   fails  = 0;

  always #5 clock = ~clock;

  instr_sequencer_if bus();
  instr_sequencer_if bus_w2();

  instr_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  instr_sequencer #(.MEM_WAIT_MAX(2)) dut_w2 (
    .clock (clock),
    .clear (clear),
    .bus   (bus_w2.master)
  );

  // {Rin, Rout, ALUop, PCin PCout MARin MDRin MDRout IRin Yin Zlowin Zhighin
  //  Zlowout Zhighout HIin LOin IncPC Read ALU_MUL ALU_DIV}
  wire logic [52:0] obs = {bus.Rin, bus.Rout, bus.ALUop, bus.PCin, bus.PCout,
    bus.MARin, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin,
    bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin, bus.IncPC, bus.Read,
    bus.ALU_MUL, bus.ALU_DIV};
  wire logic [52:0] obs_w2 = {bus_w2.Rin, bus_w2.Rout, bus_w2.ALUop, bus_w2.PCin,
    bus_w2.PCout, bus_w2.MARin, bus_w2.MDRin, bus_w2.MDRout, bus_w2.IRin, bus_w2.Yin,
    bus_w2.Zlowin, bus_w2.Zhighin, bus_w2.Zlowout, bus_w2.Zhighout, bus_w2.HIin,
    bus_w2.LOin, bus_w2.IncPC, bus_w2.Read, bus_w2.ALU_MUL, bus_w2.ALU_DIV};

  localparam logic [52:0] E_PCIN     = 53'd1 << 16;
  localparam logic [52:0] E_PCOUT    = 53'd1 << 15;
  localparam logic [52:0] E_MARIN    = 53'd1 << 14;
  localparam logic [52:0] E_MDRIN    = 53'd1 << 13;
  localparam logic [52:0] E_MDROUT   = 53'd1 << 12;
  localparam logic [52:0] E_IRIN     = 53'd1 << 11;
  localparam logic [52:0] E_YIN      = 53'd1 << 10;
  localparam logic [52:0] E_ZLOWIN   = 53'd1 << 9;
  localparam logic [52:0] E_ZHIGHIN  = 53'd1 << 8;
  localparam logic [52:0] E_ZLOWOUT  = 53'd1 << 7;
  localparam logic [52:0] E_ZHIGHOUT = 53'd1 << 6;
  localparam logic [52:0] E_HIIN     = 53'd1 << 5;
  localparam logic [52:0] E_LOIN     = 53'd1 << 4;
  localparam logic [52:0] E_INCPC    = 53'd1 << 3;
  localparam logic [52:0] E_READ     = 53'd1 << 2;
  localparam logic [52:0] E_ALU_MUL  = 53'd1 << 1;
  localparam logic [52:0] E_ALU_DIV  = 53'd1 << 0;
  localparam logic [52:0] E_T0 = E_PCOUT | E_MARIN | E_INCPC | E_ZLOWIN;
  localparam logic [52:0] E_T1 = E_ZLOWOUT | E_PCIN | E_READ | E_MDRIN;
  localparam logic [52:0] E_T2 = E_MDROUT | E_IRIN;

  function automatic logic [52:0] e_rin(input int k);
    return 53'd1 << (37 + k);
  endfunction

  function automatic logic [52:0] e_rout(input int k);
    return 53'd1 << (21 + k);
  endfunction

  function automatic logic [52:0] e_alu(input logic [3:0] v);
    return {32'd0, v, 17'd0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step();
    bus.run = 1'b0;
    bus_w2.run = 1'b0;
    bus.mem_rdy = 1'b1;
    clear = 1'b0;
    #3;
    clear = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 53'd0) begin
      fails++; $display("FAIL reset_strobes: got %h want 0", obs);
    end
    checks++;
    if ({bus.busy, bus.halted, bus.fault} !== 3'b000) begin
      fails++; $display("FAIL reset_status: got %b want 000", {bus.busy, bus.halted, bus.fault});
    end
    checks++;
    if ({obs_w2 != 53'd0, bus_w2.busy, bus_w2.halted, bus_w2.fault} !== 4'b0000) begin
      fails++; $display("FAIL reset_w2: got %h want 0", obs_w2);
    end
  endtask

  task automatic test_add();
    logic [52:0] exp_seq [7];
    int busy_cycles;
    exp_seq = '{E_T0, E_T1, E_T2, e_rout(2) | E_YIN, e_rout(4) | e_alu(4'd0) | E_ZLOWIN,
                E_ZLOWOUT | e_rin(5), 53'd0};
    busy_cycles = 0;
    do_reset();
    bus.IR = 32'h1A92_0000;
    bus.mem_rdy = 1'b1;
    bus.run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      bus.run = 1'b0;
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL add_cycle%0d: got %h want %h", i, obs, exp_seq[i]);
      end
      if (bus.busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles !== 6) begin
      fails++; $display("FAIL add_busy_cycles: got %0d want 6", busy_cycles);
    end
  endtask

  task automatic test_muldiv();
    logic [52:0] exp_seq [8];
    int busy_cycles;
    exp_seq = '{E_T0, E_T1, E_T2, e_rout(1) | E_YIN,
                e_rout(1) | e_alu(4'd12) | E_ZLOWIN | E_ZHIGHIN | E_ALU_DIV,
                E_ZLOWOUT | E_LOIN, E_ZHIGHOUT | E_HIIN, 53'd0};
    busy_cycles = 0;
    do_reset();
    bus.IR = 32'h7988_8000;
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.run = 1'b0;
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL div_cycle%0d: got %h want %h", i, obs, exp_seq[i]);
      end
      if (bus.busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles !== 7) begin
      fails++; $display("FAIL div_busy_cycles: got %0d want 7", busy_cycles);
    end
    exp_seq = '{E_T0, E_T1, E_T2, e_rout(2) | E_YIN,
                e_rout(3) | e_alu(4'd11) | E_ZLOWIN | E_ZHIGHIN | E_ALU_MUL,
                E_ZLOWOUT | E_LOIN, E_ZHIGHOUT | E_HIIN, 53'd0};
    bus.IR = 32'h8091_8000;
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.run = 1'b0;
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL mul_cycle%0d: got %h want %h", i, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_unary();
    logic [52:0] exp_seq [7];
    exp_seq = '{E_T0, E_T1, E_T2, 53'd0, e_rout(7) | e_alu(4'd9) | E_ZLOWIN,
                E_ZLOWOUT | e_rin(6), 53'd0};
    do_reset();
    bus.IR = 32'h8B38_0000;
    bus.run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      bus.run = 1'b0;
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL neg_cycle%0d: got %h want %h", i, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [52:0] exp_seq [8];
    int irin_cycles;
    exp_seq = '{E_T0, E_T1, E_T1, E_T1, E_T1, E_T2, 53'd0, 53'd0};
    irin_cycles = 0;
    do_reset();
    bus.IR = 32'hD000_0000;
    bus.mem_rdy = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.run = 1'b0;
      bus.mem_rdy = (i >= 4);
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL memwait_cycle%0d: got %h want %h", i, obs, exp_seq[i]);
      end
      if (bus.IRin) irin_cycles++;
      if (i == 6) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          fails++; $display("FAIL memwait_t3_busy: got %b want 1", bus.busy);
        end
      end
    end
    checks++;
    if (irin_cycles !== 1) begin
      fails++; $display("FAIL memwait_irin_cycles: got %0d want 1", irin_cycles);
    end
    checks++;
    if ({bus.busy, bus.fault} !== 2'b00) begin
      fails++; $display("FAIL memwait_end_status: got %b want 00", {bus.busy, bus.fault});
    end
  endtask

  task automatic test_mem_timeout();
    logic [52:0] exp_seq [4];
    exp_seq = '{E_T0, E_T1, E_T1, 53'd0};
    do_reset();
    bus_w2.IR = 32'hD000_0000;
    bus_w2.mem_rdy = 1'b0;
    bus_w2.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_w2 !== exp_seq[i]) begin
        fails++; $display("FAIL timeout_cycle%0d: got %h want %h", i, obs_w2, exp_seq[i]);
      end
    end
    bus_w2.mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({obs_w2 != 53'd0, bus_w2.busy, bus_w2.halted, bus_w2.fault} !== 4'b0011) begin
        fails++; $display("FAIL timeout_halt%0d: got strobes %h status %b want 0/011", i, obs_w2,
                          {bus_w2.busy, bus_w2.halted, bus_w2.fault});
      end
    end
    bus_w2.run = 1'b0;
  endtask

  task automatic test_halt();
    logic [52:0] exp_seq [4];
    int bad;
    exp_seq = '{E_T0, E_T1, E_T2, 53'd0};
    bad = 0;
    do_reset();
    bus.IR = 32'hD800_0000;
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL halt_fetch%0d: got %h want %h", i, obs, exp_seq[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({obs != 53'd0, bus.busy, bus.halted, bus.fault} !== 4'b0010) begin
        fails++; $display("FAIL halt_hold%0d: got strobes %h status %b want 0/010", i, obs,
                          {bus.busy, bus.halted, bus.fault});
      end
    end
  endtask

  task automatic test_illegal();
    logic [52:0] exp_seq [4];
    int rin_seen;
    exp_seq = '{E_T0, E_T1, E_T2, 53'd0};
    rin_seen = 0;
    do_reset();
    bus.IR = 32'hFA90_0000;
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL illegal_fetch%0d: got %h want %h", i, obs, exp_seq[i]);
      end
    end
    step();
`ifdef ILLEGAL_OP_TRAP_EN
    checks++;
    if ({obs != 53'd0, bus.busy, bus.halted, bus.fault} !== 4'b0011) begin
      fails++; $display("FAIL illegal_trap: got strobes %h status %b want 0/011", obs,
                        {bus.busy, bus.halted, bus.fault});
    end
`else
    checks++;
    if (obs !== E_T0) begin
      fails++; $display("FAIL illegal_as_nop: got %h want %h", obs, E_T0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.Rin != 16'd0) rin_seen++;
    end
    checks++;
    if ({rin_seen != 0, bus.fault} !== 2'b00) begin
      fails++; $display("FAIL illegal_no_rin: got rin cycles %0d fault %b want 0/0", rin_seen, bus.fault);
    end
`endif
    bus.run = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [52:0] exp_seq [8];
    exp_seq = '{E_T0, E_T1, E_T2, e_rout(2) | E_YIN, e_rout(4) | e_alu(4'd0) | E_ZLOWIN,
                E_ZLOWOUT | e_rin(5), E_T0, E_T1};
    do_reset();
    bus.IR = 32'h1A92_0000;
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs !== exp_seq[i]) begin
        fails++; $display("FAIL b2b_cycle%0d: got %h want %h", i, obs, exp_seq[i]);
      end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_reset_mid_t4();
    do_reset();
    bus.IR = 32'h1A92_0000;
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (obs !== (e_rout(4) | e_alu(4'd0) | E_ZLOWIN)) begin
      fails++; $display("FAIL midreset_in_t4: got %h want %h", obs, e_rout(4) | E_ZLOWIN);
    end
    clear = 1'b0;
    #1;
    checks++;
    if ({obs != 53'd0, bus.busy} !== 2'b00) begin
      fails++; $display("FAIL midreset_async: got strobes %h busy %b want 0/0", obs, bus.busy);
    end
    clear = 1'b1;
    step();
    checks++;
    if (obs !== E_T0) begin
      fails++; $display("FAIL midreset_restart: got %h want %h", obs, E_T0);
    end
    bus.run = 1'b0;
  endtask

  initial begin
    clear = 1'b0;
    bus.run = 1'b0;
    bus.IR = 32'd0;
    bus.mem_rdy = 1'b1;
    bus_w2.run = 1'b0;
    bus_w2.IR = 32'd0;
    bus_w2.mem_rdy = 1'b1;
    test_reset();
    test_add();
    test_muldiv();
    test_unary();
    test_mem_wait();
    test_mem_timeout();
    test_halt();
    test_illegal();
    test_back_to_back();
    test_reset_mid_t4();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
